nh_lcd_bus_arbiter: RTL and testbench

Shares the single 8-bit 8080-style NH LCD physical bus between two requesters: the command/register engine (CMD port) and the pixel data writer (PIX port). Grants the bus to one owner at a time and registers that owner's bus signals onto the pads. Inserts idle turnaround cycles between owners and asks a long-running pixel burst to yield when commands are waiting. Sits between the requesters and the LCD I/O pads inside the wb_nh_lcd slave.

---
 rtl/nh_lcd_bus_arbiter_if.sv | 43 ++++
 rtl/nh_lcd_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_nh_lcd_bus_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/nh_lcd_bus_arbiter_if.sv
// Bus bundle between the CMD/PIX requesters and the NH LCD pad arbiter.
// The arbiter takes the slave view; the requesters (or a bench) take the master view.
interface nh_lcd_bus_arbiter_if;
    // CMD requester side
    logic       i_cmd_req;
    logic       o_cmd_gnt;
    logic       i_cmd_cmd_mode;
    logic [7:0] i_cmd_data_out;
    logic       i_cmd_write;
    logic       i_cmd_read;
    logic       i_cmd_data_out_en;

    // PIX requester side
    logic       i_pix_req;
    logic       o_pix_gnt;
    logic       o_pix_yield;
    logic       i_pix_cmd_mode;
    logic [7:0] i_pix_data_out;
    logic       i_pix_write;
    logic       i_pix_read;
    logic       i_pix_data_out_en;

    // Pad side
    logic       o_cmd_mode;
    logic [7:0] o_data_out;
    logic       o_write;
    logic       o_read;
    logic       o_data_out_en;

    modport slave (
        input  i_cmd_req, i_cmd_cmd_mode, i_cmd_data_out, i_cmd_write, i_cmd_read, i_cmd_data_out_en,
        input  i_pix_req, i_pix_cmd_mode, i_pix_data_out, i_pix_write, i_pix_read, i_pix_data_out_en,
        output o_cmd_gnt, o_pix_gnt, o_pix_yield,
        output o_cmd_mode, o_data_out, o_write, o_read, o_data_out_en
    );

    modport master (
        output i_cmd_req, i_cmd_cmd_mode, i_cmd_data_out, i_cmd_write, i_cmd_read, i_cmd_data_out_en,
        output i_pix_req, i_pix_cmd_mode, i_pix_data_out, i_pix_write, i_pix_read, i_pix_data_out_en,
        input  o_cmd_gnt, o_pix_gnt, o_pix_yield,
        input  o_cmd_mode, o_data_out, o_write, o_read, o_data_out_en
    );
endinterface

// File: rtl/nh_lcd_bus_arbiter.sv
// NH LCD 8080 bus arbiter: shares the pad bus between the command engine (CMD)
// and the pixel writer (PIX). Round-robin grant from IDLE, registered pad
// outputs from the current owner only, idle turnaround between owners, and an
// advisory yield request to PIX when a CMD request has been waiting too long.
module nh_lcd_bus_arbiter #(
    parameter int TURNAROUND_CYCLES = 2,     // 1..15
    parameter int HOLD_LIMIT        = 1024   // 0 disables yield
) (
    input  logic                        clk,
    input  logic                        rst,
    nh_lcd_bus_arbiter_if.slave         bus,
    output logic [31:0]                 debug
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT_CMD  = 2'd1,
        ST_GRANT_PIX  = 2'd2,
        ST_TURNAROUND = 2'd3
    } state_t;

    localparam logic        OWNER_CMD = 1'b0;
    localparam logic        OWNER_PIX = 1'b1;
    localparam logic [3:0]  TA_LAST   = 4'(TURNAROUND_CYCLES - 1);
    localparam logic [15:0] HOLD_MAX  = 16'(HOLD_LIMIT);
    localparam logic        YIELD_ON  = (HOLD_LIMIT != 0);

    // Pad idle values
    localparam logic       IDLE_CMD_MODE = 1'b1;
    localparam logic [7:0] IDLE_DATA     = 8'h00;
    localparam logic       IDLE_WRITE    = 1'b0;
    localparam logic       IDLE_READ     = 1'b0;
    localparam logic       IDLE_OE       = 1'b1;

    state_t      state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic [3:0]  ta_cnt_q, ta_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        cmd_gnt_q, cmd_gnt_d;
    logic        pix_gnt_q, pix_gnt_d;
    logic        pix_yield_q, pix_yield_d;
    logic        pad_cmd_mode_q, pad_cmd_mode_d;
    logic [7:0]  pad_data_q, pad_data_d;
    logic        pad_write_q, pad_write_d;
    logic        pad_read_q, pad_read_d;
    logic        pad_oe_q, pad_oe_d;

    // Next-state logic: round-robin grant, release on request drop, timed turnaround
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        ta_cnt_d     = ta_cnt_q;
        if (rst) begin
            state_d      = ST_IDLE;
            last_owner_d = OWNER_PIX;
            ta_cnt_d     = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_cmd_req && bus.i_pix_req) begin
                        // Both waiting: favour whoever did not own the bus last
                        if (last_owner_q == OWNER_PIX) begin
                            state_d = ST_GRANT_CMD;
                        end else begin
                            state_d = ST_GRANT_PIX;
                        end
                    end else if (bus.i_cmd_req) begin
                        state_d = ST_GRANT_CMD;
                    end else if (bus.i_pix_req) begin
                        state_d = ST_GRANT_PIX;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_GRANT_CMD: begin
                    if (!bus.i_cmd_req) begin
                        state_d      = ST_TURNAROUND;
                        last_owner_d = OWNER_CMD;
                        ta_cnt_d     = 4'd0;
                    end else begin
                        state_d = ST_GRANT_CMD;
                    end
                end
                ST_GRANT_PIX: begin
                    if (!bus.i_pix_req) begin
                        state_d      = ST_TURNAROUND;
                        last_owner_d = OWNER_PIX;
                        ta_cnt_d     = 4'd0;
                    end else begin
                        state_d = ST_GRANT_PIX;
                    end
                end
                ST_TURNAROUND: begin
                    // Stay for exactly TURNAROUND_CYCLES cycles
                    if (ta_cnt_q == TA_LAST) begin
                        state_d  = ST_IDLE;
                        ta_cnt_d = 4'd0;
                    end else begin
                        ta_cnt_d = ta_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    ta_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // Grant outputs: visible one cycle after entering the grant state, only while the request holds
    always_comb begin
        cmd_gnt_d = 1'b0;
        pix_gnt_d = 1'b0;
        if (rst) begin
            cmd_gnt_d = 1'b0;
            pix_gnt_d = 1'b0;
        end else begin
            cmd_gnt_d = (state_q == ST_GRANT_CMD) && bus.i_cmd_req;
            pix_gnt_d = (state_q == ST_GRANT_PIX) && bus.i_pix_req;
        end
    end

    // Pad mux: forward only the visible owner's signals, otherwise drive idle values
    always_comb begin
        pad_cmd_mode_d = IDLE_CMD_MODE;
        pad_data_d     = IDLE_DATA;
        pad_write_d    = IDLE_WRITE;
        pad_read_d     = IDLE_READ;
        pad_oe_d       = IDLE_OE;
        if (rst) begin
            pad_cmd_mode_d = IDLE_CMD_MODE;
            pad_data_d     = IDLE_DATA;
            pad_write_d    = IDLE_WRITE;
            pad_read_d     = IDLE_READ;
            pad_oe_d       = IDLE_OE;
        end else if (cmd_gnt_q && bus.i_cmd_req) begin
            pad_cmd_mode_d = bus.i_cmd_cmd_mode;
            pad_data_d     = bus.i_cmd_data_out;
            pad_write_d    = bus.i_cmd_write;
            pad_read_d     = bus.i_cmd_read;
            pad_oe_d       = bus.i_cmd_data_out_en;
        end else if (pix_gnt_q && bus.i_pix_req) begin
            pad_cmd_mode_d = bus.i_pix_cmd_mode;
            pad_data_d     = bus.i_pix_data_out;
            pad_write_d    = bus.i_pix_write;
            pad_read_d     = bus.i_pix_read;
            pad_oe_d       = bus.i_pix_data_out_en;
        end else begin
            pad_cmd_mode_d = IDLE_CMD_MODE;
            pad_data_d     = IDLE_DATA;
            pad_write_d    = IDLE_WRITE;
            pad_read_d     = IDLE_READ;
            pad_oe_d       = IDLE_OE;
        end
    end

    // Hold counter: cycles a CMD request has waited during the current PIX grant
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (rst) begin
            hold_cnt_d = 16'd0;
        end else if ((state_q != ST_GRANT_PIX) && (state_d == ST_GRANT_PIX)) begin
            hold_cnt_d = 16'd0;
        end else if ((state_q == ST_GRANT_PIX) && bus.i_cmd_req && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + 16'd1;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // Yield: raised the cycle after the hold limit is reached, held until PIX leaves its grant
    always_comb begin
        pix_yield_d = 1'b0;
        if (YIELD_ON && (state_q == ST_GRANT_PIX) && (state_d == ST_GRANT_PIX)) begin
            pix_yield_d = (hold_cnt_q == HOLD_MAX) || pix_yield_q;
        end else begin
            pix_yield_d = 1'b0;
        end
    end

    // State and output registers (reset folded into the _d logic above)
    always_ff @(posedge clk) begin
        state_q        <= state_d;
        last_owner_q   <= last_owner_d;
        ta_cnt_q       <= ta_cnt_d;
        hold_cnt_q     <= hold_cnt_d;
        cmd_gnt_q      <= cmd_gnt_d;
        pix_gnt_q      <= pix_gnt_d;
        pix_yield_q    <= pix_yield_d;
        pad_cmd_mode_q <= pad_cmd_mode_d;
        pad_data_q     <= pad_data_d;
        pad_write_q    <= pad_write_d;
        pad_read_q     <= pad_read_d;
        pad_oe_q       <= pad_oe_d;
    end

    assign bus.o_cmd_gnt     = cmd_gnt_q;
    assign bus.o_pix_gnt     = pix_gnt_q;
    assign bus.o_pix_yield   = pix_yield_q;
    assign bus.o_cmd_mode    = pad_cmd_mode_q;
    assign bus.o_data_out    = pad_data_q;
    assign bus.o_write       = pad_write_q;
    assign bus.o_read        = pad_read_q;
    assign bus.o_data_out_en = pad_oe_q;

    assign debug = {24'd0, ta_cnt_q, pix_yield_q, last_owner_q, state_q};

endmodule

// File: tb/tb_nh_lcd_bus_arbiter.sv
// Directed bench for nh_lcd_bus_arbiter: a per-cycle vector table for reset,
// grant latency, pad forwarding and round-robin, then hand sequences for
// yield, non-owner isolation and reset in the middle of a grant.
module tb_nh_lcd_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] debug8;
    logic [31:0] debug0;
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    nh_lcd_bus_arbiter_if bus8 ();
    nh_lcd_bus_arbiter_if bus0 ();

    // Second instance with yield disabled sees identical stimulus
    assign bus0.i_cmd_req         = bus8.i_cmd_req;
    assign bus0.i_cmd_cmd_mode    = bus8.i_cmd_cmd_mode;
    assign bus0.i_cmd_data_out    = bus8.i_cmd_data_out;
    assign bus0.i_cmd_write       = bus8.i_cmd_write;
    assign bus0.i_cmd_read        = bus8.i_cmd_read;
    assign bus0.i_cmd_data_out_en = bus8.i_cmd_data_out_en;
    assign bus0.i_pix_req         = bus8.i_pix_req;
    assign bus0.i_pix_cmd_mode    = bus8.i_pix_cmd_mode;
    assign bus0.i_pix_data_out    = bus8.i_pix_data_out;
    assign bus0.i_pix_write       = bus8.i_pix_write;
    assign bus0.i_pix_read        = bus8.i_pix_read;
    assign bus0.i_pix_data_out_en = bus8.i_pix_data_out_en;

    nh_lcd_bus_arbiter #(.TURNAROUND_CYCLES(2), .HOLD_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .bus(bus8.slave), .debug(debug8)
    );

    nh_lcd_bus_arbiter #(.TURNAROUND_CYCLES(2), .HOLD_LIMIT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .debug(debug0)
    );

    typedef struct {
        logic       rst;
        logic       creq;
        logic       cw;
        logic [7:0] cd;
        logic       preq;
        logic       e_cgnt;
        logic       e_pgnt;
        logic       e_write;
        logic [7:0] e_data;
        logic [1:0] e_state;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic r, logic cq, logic cw, logic [7:0] cd, logic pq,
                                logic eg_c, logic eg_p, logic e_w, logic [7:0] e_d, logic [1:0] e_st);
        vec_t v;
        v.rst = r; v.creq = cq; v.cw = cw; v.cd = cd; v.preq = pq;
        v.e_cgnt = eg_c; v.e_pgnt = eg_p; v.e_write = e_w; v.e_data = e_d; v.e_state = e_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus8.i_cmd_req = 1'b0; bus8.i_cmd_cmd_mode = 1'b1; bus8.i_cmd_data_out = 8'h00;
        bus8.i_cmd_write = 1'b0; bus8.i_cmd_read = 1'b0; bus8.i_cmd_data_out_en = 1'b1;
        bus8.i_pix_req = 1'b0; bus8.i_pix_cmd_mode = 1'b1; bus8.i_pix_data_out = 8'h00;
        bus8.i_pix_write = 1'b0; bus8.i_pix_read = 1'b0; bus8.i_pix_data_out_en = 1'b1;
    endtask

    task automatic reset_cycle();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [13:0] act_v, exp_v;
    int          n_wait;
    logic [7:0]  pd;
    logic        pw, pr;

    initial begin
        clear_inputs();

        //            rst creq cw  cd     preq  cgnt pgnt w   data   st
        vecs[0]  = mk(1'b1,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,2'd0); // reset, both requesting
        vecs[1]  = mk(1'b1,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,2'd0);
        vecs[2]  = mk(1'b1,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,2'd0);
        vecs[3]  = mk(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,2'd1); // CMD sampled in IDLE
        vecs[4]  = mk(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,1'b0,8'h00,2'd1); // gnt visible
        vecs[5]  = mk(1'b0,1'b1,1'b1,8'h2C,1'b0, 1'b1,1'b0,1'b1,8'h2C,2'd1); // write 0x2C forwarded
        vecs[6]  = mk(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,1'b0,8'h00,2'd1);
        vecs[7]  = mk(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,2'd3); // release -> turnaround
        vecs[8]  = mk(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,2'd3);
        vecs[9]  = mk(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,2'd0);
        vecs[10] = mk(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,2'd0);
        vecs[11] = mk(1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,2'd0); // reset: last_owner = PIX
        vecs[12] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,2'd1); // both -> CMD
        vecs[13] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h00,2'd1);
        vecs[14] = mk(1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,2'd3);
        vecs[15] = mk(1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,2'd3);
        vecs[16] = mk(1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,2'd0);
        vecs[17] = mk(1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,2'd2); // PIX granted
        vecs[18] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,1'b0,8'h00,2'd2);
        vecs[19] = mk(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,2'd3);
        vecs[20] = mk(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,2'd3);
        vecs[21] = mk(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,2'd0);
        vecs[22] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,2'd1); // both -> CMD again
        vecs[23] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h00,2'd1);
        vecs[24] = mk(1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,2'd3);

        for (int i = 0; i < NVEC; i++) begin
            rst                 = vecs[i].rst;
            bus8.i_cmd_req      = vecs[i].creq;
            bus8.i_cmd_write    = vecs[i].cw;
            bus8.i_cmd_data_out = vecs[i].cd;
            bus8.i_pix_req      = vecs[i].preq;
            step();
            act_v = {bus8.o_cmd_gnt, bus8.o_pix_gnt, bus8.o_pix_yield, bus8.o_write,
                     bus8.o_data_out, debug8[1:0]};
            exp_v = {vecs[i].e_cgnt, vecs[i].e_pgnt, 1'b0, vecs[i].e_write,
                     vecs[i].e_data, vecs[i].e_state};
            chk($sformatf("vec%0d{cg,pg,y,w,d,st}", i), {50'd0, act_v}, {50'd0, exp_v});
            if (vecs[i].rst) begin
                chk($sformatf("vec%0d_rst_mode_oe", i),
                    {62'd0, bus8.o_cmd_mode, bus8.o_data_out_en}, 64'd3);
            end
        end

        // Yield after HOLD_LIMIT = 8 waiting cycles, then CMD after turnaround
        reset_cycle();
        bus8.i_pix_req = 1'b1;
        step();
        step();
        chk("yield_pix_gnt", {63'd0, bus8.o_pix_gnt}, 64'd1);
        bus8.i_cmd_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("yield_k%0d", k), {63'd0, bus8.o_pix_yield}, {63'd0, (k == 9)});
        end
        chk("yield_dbg_bit", {63'd0, debug8[3]}, 64'd1);
        chk("yield_no_preempt", {63'd0, bus8.o_pix_gnt}, 64'd1);
        bus8.i_pix_req = 1'b0;
        step();
        chk("yield_clear", {62'd0, bus8.o_pix_yield, bus8.o_pix_gnt}, 64'd0);
        n_wait = 0;
        while (!bus8.o_cmd_gnt && n_wait < 10) begin
            step();
            n_wait++;
        end
        chk("yield_cmd_gnt_delay", 64'(n_wait), 64'd4);
        bus8.i_cmd_req = 1'b0;
        step();

        // Non-owner isolation while PIX owns the bus; HOLD_LIMIT = 0 never yields
        reset_cycle();
        bus8.i_pix_req = 1'b1;
        bus8.i_pix_cmd_mode = 1'b0;
        bus8.i_pix_data_out_en = 1'b0;
        step();
        step();
        bus8.i_cmd_req = 1'b1;
        bus8.i_cmd_data_out = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            pd = 8'h10 + 8'(i);
            pw = i[0];
            pr = ~i[0];
            bus8.i_pix_data_out = pd;
            bus8.i_pix_write    = pw;
            bus8.i_pix_read     = pr;
            bus8.i_cmd_write    = ~i[0];
            bus8.i_cmd_read     = i[0];
            step();
            chk($sformatf("iso%0d{mode,oe,w,r,d}", i),
                {52'd0, bus8.o_cmd_mode, bus8.o_data_out_en, bus8.o_write, bus8.o_read, bus8.o_data_out},
                {52'd0, 1'b0, 1'b0, pw, pr, pd});
            chk($sformatf("iso%0d_hold0_yield", i), {63'd0, bus0.o_pix_yield}, 64'd0);
        end
        chk("iso_hold8_yield", {63'd0, bus8.o_pix_yield}, 64'd1);
        chk("iso_cmd_gnt", {63'd0, bus8.o_cmd_gnt}, 64'd0);

        // Reset in the middle of a PIX write
        bus8.i_pix_write = 1'b1;
        bus8.i_pix_read  = 1'b0;
        step();
        chk("midrst_pre_write", {63'd0, bus8.o_write}, 64'd1);
        rst = 1'b1;
        step();
        chk("midrst{w,pg,y,st,mode,oe,d}",
            {50'd0, bus8.o_write, bus8.o_pix_gnt, bus8.o_pix_yield, debug8[1:0],
             bus8.o_cmd_mode, bus8.o_data_out_en, bus8.o_data_out},
            {50'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 8'h00});
        rst = 1'b0;
        clear_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
